// File: rtl/md5_pkg.sv
// ---------------------------------------------------------------------------
// md5_pkg
// Shared definitions for the MD5 front end (md5_msg_padder) and md5_core_block.
//   - md5_state_e     : padder FSM states
//   - MD5_BLOCK_BYTES : bytes per 512-bit block
//   - MD5_BLOCK_BITS  : block width in bits
//   - MD5_LEN_OFFSET  : byte offset of the 64-bit length field
//   - MD5_PAD_BYTE    : first padding byte
// ---------------------------------------------------------------------------
package md5_pkg;

  localparam int unsigned MD5_BLOCK_BYTES = 64;
  localparam int unsigned MD5_BLOCK_BITS  = 8 * MD5_BLOCK_BYTES;
  localparam int unsigned MD5_LEN_OFFSET  = 56;
  localparam logic [7:0]  MD5_PAD_BYTE    = 8'h80;

  typedef enum logic [2:0] {
    FILL = 3'd0,
    PAD  = 3'd1,
    ZERO = 3'd2,
    LEN  = 3'd3,
    EMIT = 3'd4
  } md5_state_e;

endpackage

// File: rtl/md5_msg_padder.sv
// ---------------------------------------------------------------------------
// md5_msg_padder
// Collects a byte-serial message into 512-bit blocks, appends MD5 padding
// (0x80, zero fill, 64-bit little-endian bit length) and hands each block to
// the core over a valid/ready handshake.
//
// Optional build macro: MD5_PAD_FASTZERO_EN
//   defined   -> the zero fill of a block is written in a single cycle
//   undefined -> the zero fill is written one byte per cycle
//
// Ports:
//   clk         in   clock
//   reset       in   asynchronous, active-high reset
//   in_data     in   [7:0] message byte
//   in_valid    in   beat valid
//   in_last     in   final beat of the message
//   in_keep     in   in_data is a real byte (0 only on an empty final beat)
//   in_ready    out  a beat is accepted this cycle when in_valid is high
//   block_out   out  [511:0] block, message byte i at [8*i+7:8*i]
//   block_valid out  block_out holds a complete block
//   block_last  out  block carries the length field
//   block_ready in   downstream consumes the block
// ---------------------------------------------------------------------------
module md5_msg_padder
  import md5_pkg::*;
#(
  parameter int unsigned LEN_W = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  input  logic                      in_keep,
  output logic                      in_ready,
  output logic [MD5_BLOCK_BITS-1:0] block_out,
  output logic                      block_valid,
  output logic                      block_last,
  input  logic                      block_ready
);

  localparam logic [5:0]       LenOffPtr = 6'(MD5_LEN_OFFSET);
  localparam logic [5:0]       LastPtr   = 6'(MD5_BLOCK_BYTES - 1);
  localparam logic [LEN_W-1:0] CountOne  = LEN_W'(1);

  md5_state_e                state_q, state_d;
  md5_state_e                ret_q, ret_d;       // where EMIT goes after a non-final block
  logic [5:0]                ptr_q, ptr_d;
  logic [LEN_W-1:0]          count_q, count_d;
  logic                      need_second_q, need_second_d;
  logic                      last_q, last_d;
  logic                      in_ready_q, in_ready_d;
  logic                      block_valid_q, block_valid_d;
  logic [MD5_BLOCK_BITS-1:0] buf_q, buf_d;

  // Byte-lane write port into the block buffer
  logic [MD5_BLOCK_BYTES-1:0] we;
  logic [7:0]                 wbyte [MD5_BLOCK_BYTES];

  // Bit length, zero-extended or truncated to the fixed 64-bit field
  logic [LEN_W+2:0] bit_count;
  logic [63:0]      len_field;

  assign bit_count = {count_q, 3'b000};
  assign len_field = 64'(bit_count);

  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    ptr_d         = ptr_q;
    count_d       = count_q;
    need_second_d = need_second_q;
    last_d        = last_q;
    we            = '0;
    for (int i = 0; i < MD5_BLOCK_BYTES; i++) begin
      wbyte[i] = 8'h00;
    end

    unique case (state_q)
      FILL: begin
        if (in_valid && in_ready_q) begin
          if (in_keep) begin
            we[ptr_q]    = 1'b1;
            wbyte[ptr_q] = in_data;
            ptr_d        = ptr_q + 6'd1;
            count_d      = count_q + CountOne;
            if (ptr_q == LastPtr) begin
              state_d = EMIT;
              last_d  = 1'b0;
              ret_d   = in_last ? PAD : FILL;
            end else if (in_last) begin
              state_d = PAD;
            end
          end else if (in_last) begin
            state_d = PAD;
          end
        end
      end

      PAD: begin
        we[ptr_q]     = 1'b1;
        wbyte[ptr_q]  = MD5_PAD_BYTE;
        ptr_d         = ptr_q + 6'd1;
        need_second_d = (ptr_q >= LenOffPtr);
        // 0x80 filled the last lane: block is already complete, flush it now
        if (ptr_q == LastPtr) begin
          state_d       = EMIT;
          last_d        = 1'b0;
          ret_d         = ZERO;
          need_second_d = 1'b0;
        end else begin
          state_d = ZERO;
        end
      end

      ZERO: begin
`ifdef MD5_PAD_FASTZERO_EN
        for (int i = 0; i < MD5_BLOCK_BYTES; i++) begin
          if ((6'(i) >= ptr_q) && (need_second_q || (6'(i) < LenOffPtr))) begin
            we[i] = 1'b1;
          end
        end
        if (need_second_q) begin
          state_d       = EMIT;
          last_d        = 1'b0;
          ret_d         = ZERO;
          need_second_d = 1'b0;
          ptr_d         = 6'd0;
        end else begin
          state_d = LEN;
          ptr_d   = LenOffPtr;
        end
`else
        if (!need_second_q && (ptr_q == LenOffPtr)) begin
          state_d = LEN;
        end else begin
          we[ptr_q] = 1'b1;
          ptr_d     = ptr_q + 6'd1;
          if (need_second_q && (ptr_q == LastPtr)) begin
            state_d       = EMIT;
            last_d        = 1'b0;
            ret_d         = ZERO;
            need_second_d = 1'b0;
          end else if (!need_second_q && (ptr_q == LenOffPtr - 6'd1)) begin
            state_d = LEN;
          end
        end
`endif
      end

      LEN: begin
        for (int k = 0; k < 8; k++) begin
          we[MD5_LEN_OFFSET + k]    = 1'b1;
          wbyte[MD5_LEN_OFFSET + k] = len_field[8*k +: 8];
        end
        ptr_d   = 6'd0;
        state_d = EMIT;
        last_d  = 1'b1;
        ret_d   = FILL;
      end

      EMIT: begin
        if (block_ready) begin
          if (last_q) begin
            count_d = '0;
            state_d = FILL;
          end else begin
            state_d = ret_q;
          end
          last_d = 1'b0;
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_comb begin
    buf_d = buf_q;
    for (int i = 0; i < MD5_BLOCK_BYTES; i++) begin
      if (we[i]) begin
        buf_d[8*i +: 8] = wbyte[i];
      end
    end
  end

  // Handshake outputs are registered from the next state
  assign in_ready_d    = (state_d == FILL);
  assign block_valid_d = (state_d == EMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FILL;
      ret_q         <= FILL;
      ptr_q         <= 6'd0;
      count_q       <= '0;
      need_second_q <= 1'b0;
      last_q        <= 1'b0;
      in_ready_q    <= 1'b0;
      block_valid_q <= 1'b0;
      buf_q         <= '0;
    end else begin
      state_q       <= state_d;
      ret_q         <= ret_d;
      ptr_q         <= ptr_d;
      count_q       <= count_d;
      need_second_q <= need_second_d;
      last_q        <= last_d;
      in_ready_q    <= in_ready_d;
      block_valid_q <= block_valid_d;
      buf_q         <= buf_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign block_valid = block_valid_q;
  assign block_last  = last_q;
  assign block_out   = buf_q;

endmodule

// File: tb/tb_md5_msg_padder.sv
module tb_md5_msg_padder;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   in_data = 8'h00;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         in_keep = 1'b0;
  logic         in_ready;
  logic [511:0] block_out;
  logic         block_valid;
  logic         block_last;
  logic         block_ready = 1'b1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int valid_cyc = 0;
  int start_cyc = 0;

`ifdef MD5_PAD_FASTZERO_EN
  localparam int AbcLat = 6;
`else
  localparam int AbcLat = 57;
`endif

  md5_msg_padder #(.LEN_W(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_keep    (in_keep),
    .in_ready   (in_ready),
    .block_out  (block_out),
    .block_valid(block_valid),
    .block_last (block_last),
    .block_ready(block_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Present one beat and hold it until the padder takes it
  task automatic send(input logic [7:0] d, input logic l, input logic k);
    int n = 0;
    @(negedge clk);
    in_data  = d;
    in_last  = l;
    in_keep  = k;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) chk("in_ready_timeout", in_ready, 1);
    acc_cyc = cyc;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_keep  = 1'b0;
  endtask

  task automatic wait_block(input string tag, input logic [511:0] want, input logic want_last);
    int n = 0;
    while (block_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    valid_cyc = cyc;
    chk({tag, "_valid"}, block_valid, 1);
    chk({tag, "_data"}, block_out, want);
    chk({tag, "_last"}, block_last, want_last);
    if (block_ready) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_drop"}, block_valid, 0);
    end
  endtask

  logic [511:0] e_abc, e1, e2;

  initial begin
    e_abc = '0;
    e_abc[7:0] = 8'h61; e_abc[15:8] = 8'h62; e_abc[23:16] = 8'h63; e_abc[31:24] = 8'h80;
    e_abc[8*56 +: 8] = 8'h18;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_block_valid", block_valid, 0);
    chk("rst_block_last", block_last, 0);
    chk("rst_block_out", block_out, 0);
    reset = 1'b0;
    #1 chk("in_ready_after_deassert", in_ready, 0);
    @(negedge clk);
    chk("in_ready_rise", in_ready, 1);

    // "abc" with latency check
    send(8'h61, 1'b0, 1'b1);
    start_cyc = acc_cyc;
    send(8'h62, 1'b0, 1'b1);
    send(8'h63, 1'b1, 1'b1);
    idle();
    wait_block("abc", e_abc, 1'b1);
    chk("abc_latency", 512'(valid_cyc - start_cyc), 512'(AbcLat));

    // Empty message
    e1 = '0;
    e1[7:0] = 8'h80;
    send(8'h00, 1'b1, 1'b0);
    idle();
    wait_block("empty", e1, 1'b1);

    // 55 bytes of 0x41: 440 bits = 0x1B8
    e1 = '0;
    for (int i = 0; i < 55; i++) e1[8*i +: 8] = 8'h41;
    e1[8*55 +: 8] = 8'h80;
    e1[8*56 +: 8] = 8'hB8;
    e1[8*57 +: 8] = 8'h01;
    for (int i = 0; i < 55; i++) send(8'h41, (i == 54), 1'b1);
    idle();
    wait_block("len55", e1, 1'b1);

    // 56 bytes of 0x41: length spills into a second block, 448 bits = 0x1C0
    e1 = '0;
    for (int i = 0; i < 56; i++) e1[8*i +: 8] = 8'h41;
    e1[8*56 +: 8] = 8'h80;
    e2 = '0;
    e2[8*56 +: 8] = 8'hC0;
    e2[8*57 +: 8] = 8'h01;
    for (int i = 0; i < 56; i++) send(8'h41, (i == 55), 1'b1);
    idle();
    wait_block("len56_b1", e1, 1'b0);
    wait_block("len56_b2", e2, 1'b1);

    // 64 data bytes then an empty last beat: 512 bits = 0x200
    e1 = '0;
    for (int i = 0; i < 64; i++) e1[8*i +: 8] = 8'(i);
    e2 = '0;
    e2[7:0] = 8'h80;
    e2[8*57 +: 8] = 8'h02;
    for (int i = 0; i < 64; i++) send(8'(i), 1'b0, 1'b1);
    idle();
    chk("len64_emit_in_ready", in_ready, 0);
    wait_block("len64_b1", e1, 1'b0);
    send(8'h00, 1'b1, 1'b0);
    idle();
    wait_block("len64_b2", e2, 1'b1);

    // Backpressure: hold the block for 10 cycles
    block_ready = 1'b0;
    send(8'h61, 1'b0, 1'b1);
    send(8'h62, 1'b0, 1'b1);
    send(8'h63, 1'b1, 1'b1);
    idle();
    wait_block("stall", e_abc, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_data", block_out, e_abc);
      chk("stall_valid", block_valid, 1);
      chk("stall_in_ready", in_ready, 0);
    end
    block_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("stall_release_drop", block_valid, 0);

    // Reset in the middle of a message
    send(8'h11, 1'b0, 1'b1);
    send(8'h22, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_block_valid", block_valid, 0);
    chk("midrst_block_last", block_last, 0);
    chk("midrst_block_out", block_out, 0);
    @(negedge clk);
    reset = 1'b0;
    send(8'h61, 1'b0, 1'b1);
    send(8'h62, 1'b0, 1'b1);
    send(8'h63, 1'b1, 1'b1);
    idle();
    wait_block("abc_after_rst", e_abc, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
